// File: rtl/fpr_wb_pkg.sv
// fpr_wb_pkg: shared types for the FPR writeback controller
package fpr_wb_pkg;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } fpr_wb_entry_t;
  typedef enum logic [2:0] {SRC_NONE, SRC_FPU, SRC_FIFO, SRC_LSU, SRC_DIV} fpr_wb_src_e;
endpackage

// File: rtl/dec_fpr_wb_ctl_if.sv
// dec_fpr_wb_ctl_if: producer, issue and FPR write-port signals of the writeback controller
interface dec_fpr_wb_ctl_if;
  logic        fpu_wb_valid;
  logic [4:0]  fpu_wb_addr;
  logic [31:0] fpu_wb_data;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_addr;
  logic [31:0] lsu_wb_data;
  logic        div_wb_valid;
  logic        div_wb_ready;
  logic [4:0]  div_wb_addr;
  logic [31:0] div_wb_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        fpr_wen;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wd;
  logic [31:0] fpr_busy;
  logic        wb_overflow;
  modport master (
    output fpu_wb_valid, fpu_wb_addr, fpu_wb_data,
    output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    output div_wb_valid, div_wb_addr, div_wb_data,
    output issue_valid, issue_addr,
    input  div_wb_ready, fpr_wen, fpr_waddr, fpr_wd, fpr_busy, wb_overflow
  );
  modport slave (
    input  fpu_wb_valid, fpu_wb_addr, fpu_wb_data,
    input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
    input  div_wb_valid, div_wb_addr, div_wb_data,
    input  issue_valid, issue_addr,
    output div_wb_ready, fpr_wen, fpr_waddr, fpr_wd, fpr_busy, wb_overflow
  );
endinterface

// File: rtl/fpr_wb_fifo.sv
// fpr_wb_fifo: pending-result FIFO with two ordered push ports and one pop
module fpr_wb_fifo
  import fpr_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push0,
  input  fpr_wb_entry_t         entry0,
  input  logic                  push1,
  input  fpr_wb_entry_t         entry1,
  input  logic                  pop,
  output fpr_wb_entry_t         head,
  output logic [DEPTH_LOG2:0]   count
);
  fpr_wb_entry_t mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rptr, wptr, wptr1;
  assign wptr1 = wptr + DEPTH_LOG2'(1);
  assign head  = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + DEPTH_LOG2'(pop);
      wptr  <= wptr + DEPTH_LOG2'(push0) + DEPTH_LOG2'(push1);
      count <= count + (DEPTH_LOG2+1)'(push0) + (DEPTH_LOG2+1)'(push1) - (DEPTH_LOG2+1)'(pop);
    end
  end
  // port 1 lands behind port 0 when both push in the same cycle
  always_ff @(posedge clk) begin
    if (!rst && push0) mem[wptr] <= entry0;
    if (!rst && push1) mem[push0 ? wptr1 : wptr] <= entry1;
  end
endmodule

// File: rtl/dec_fpr_wb_ctl.sv
// dec_fpr_wb_ctl: merges FPU, load and div/sqrt results onto one FPR write port with a busy scoreboard
module dec_fpr_wb_ctl
  import fpr_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input logic             clk,
  input logic             rst,
  dec_fpr_wb_ctl_if.slave bus
);
  logic [DEPTH_LOG2:0] count;
  fpr_wb_entry_t       head, lsu_entry, div_entry;
  fpr_wb_src_e         src;
  logic                full, pop, div_acc, lsu_lose, lsu_drop, lsu_push, div_push;
  logic [4:0]          win_addr;
  logic [31:0]         win_data, busy_set, busy_clr;
  assign lsu_entry = '{addr: bus.lsu_wb_addr, data: bus.lsu_wb_data};
  assign div_entry = '{addr: bus.div_wb_addr, data: bus.div_wb_data};
  // leaving two free slots guarantees an LSU and a div result can both be buffered
  assign bus.div_wb_ready = count <= (DEPTH_LOG2+1)'(DEPTH - 2);
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  always_comb begin
    div_acc  = bus.div_wb_valid & bus.div_wb_ready;
    src      = bus.fpu_wb_valid ? SRC_FPU  :
               count != '0      ? SRC_FIFO :
               bus.lsu_wb_valid ? SRC_LSU  :
               div_acc          ? SRC_DIV  : SRC_NONE;
    pop      = src == SRC_FIFO;
    lsu_lose = bus.lsu_wb_valid & (src != SRC_LSU);
    lsu_drop = lsu_lose & full & ~pop;
    lsu_push = lsu_lose & ~lsu_drop;
    div_push = div_acc & (src != SRC_DIV);
    win_addr = src == SRC_FPU  ? bus.fpu_wb_addr :
               src == SRC_FIFO ? head.addr       :
               src == SRC_LSU  ? bus.lsu_wb_addr : bus.div_wb_addr;
    win_data = src == SRC_FPU  ? bus.fpu_wb_data :
               src == SRC_FIFO ? head.data       :
               src == SRC_LSU  ? bus.lsu_wb_data : bus.div_wb_data;
    busy_clr = bus.fpr_wen ? 32'(1) << bus.fpr_waddr : '0;
    busy_set = bus.issue_valid ? 32'(1) << bus.issue_addr : '0;
  end
  fpr_wb_fifo #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push0  (lsu_push),
    .entry0 (lsu_entry),
    .push1  (div_push),
    .entry1 (div_entry),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fpr_wen     <= 1'b0;
      bus.fpr_waddr   <= '0;
      bus.fpr_wd      <= '0;
      bus.fpr_busy    <= '0;
      bus.wb_overflow <= 1'b0;
    end else begin
      bus.fpr_wen  <= src != SRC_NONE;
      bus.fpr_busy <= (bus.fpr_busy & ~busy_clr) | busy_set;
      if (src != SRC_NONE) begin
        bus.fpr_waddr <= win_addr;
        bus.fpr_wd    <= win_data;
      end
      if (lsu_drop) bus.wb_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dec_fpr_wb_ctl.sv
// tb_dec_fpr_wb_ctl: directed scenarios plus randomized traffic checked against a queue-based model
module tb_dec_fpr_wb_ctl;
  import fpr_wb_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dec_fpr_wb_ctl_if bus();
  dec_fpr_wb_ctl #(.DEPTH(DEPTH), .DEPTH_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  fpr_wb_entry_t q[$];
  logic        m_wen = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_busy = '0;
  logic        m_ovf = 1'b0;
  logic        last_div_acc = 1'b0;

  task automatic idle();
    bus.fpu_wb_valid = 0; bus.fpu_wb_addr = 0; bus.fpu_wb_data = 0;
    bus.lsu_wb_valid = 0; bus.lsu_wb_addr = 0; bus.lsu_wb_data = 0;
    bus.div_wb_valid = 0; bus.div_wb_addr = 0; bus.div_wb_data = 0;
    bus.issue_valid = 0; bus.issue_addr = 0;
  endtask

  // advance one clock; the model computes what the outputs must be after the edge
  task automatic step();
    fpr_wb_entry_t w;
    logic has_w, lsu_taken, div_taken, acc;
    has_w = 0; lsu_taken = 0; div_taken = 0;
    acc = !rst && bus.div_wb_valid && q.size() <= DEPTH - 2;
    last_div_acc = acc;
    if (rst) begin
      q.delete();
      m_wen = 0; m_waddr = 0; m_wd = 0; m_busy = 0; m_ovf = 0;
    end else begin
      if (bus.fpu_wb_valid) begin w = '{addr: bus.fpu_wb_addr, data: bus.fpu_wb_data}; has_w = 1; end
      else if (q.size() > 0) begin w = q.pop_front(); has_w = 1; end
      else if (bus.lsu_wb_valid) begin w = '{addr: bus.lsu_wb_addr, data: bus.lsu_wb_data}; has_w = 1; lsu_taken = 1; end
      else if (acc) begin w = '{addr: bus.div_wb_addr, data: bus.div_wb_data}; has_w = 1; div_taken = 1; end
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (bus.issue_valid) m_busy[bus.issue_addr] = 1'b1;
      if (bus.lsu_wb_valid && !lsu_taken) begin
        if (q.size() < DEPTH) q.push_back('{addr: bus.lsu_wb_addr, data: bus.lsu_wb_data});
        else m_ovf = 1;
      end
      if (acc && !div_taken) q.push_back('{addr: bus.div_wb_addr, data: bus.div_wb_data});
      m_wen = has_w;
      if (has_w) begin m_waddr = w.addr; m_wd = w.data; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle(); step(); step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.fpr_wen !== 1'b0) $display("FAIL reset_wen: got %0h expected 0", bus.fpr_wen); else passed++;
    checks++; if (bus.fpr_waddr !== 5'd0) $display("FAIL reset_waddr: got %0h expected 0", bus.fpr_waddr); else passed++;
    checks++; if (bus.fpr_wd !== 32'd0) $display("FAIL reset_wd: got %0h expected 0", bus.fpr_wd); else passed++;
    checks++; if (bus.fpr_busy !== 32'd0) $display("FAIL reset_busy: got %0h expected 0", bus.fpr_busy); else passed++;
    checks++; if (bus.wb_overflow !== 1'b0) $display("FAIL reset_ovf: got %0h expected 0", bus.wb_overflow); else passed++;
    checks++; if (bus.div_wb_ready !== 1'b1) $display("FAIL reset_ready: got %0h expected 1", bus.div_wb_ready); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    bus.issue_valid = 1; bus.issue_addr = 5; step(); idle();
    checks++; if (bus.fpr_busy[5] !== 1'b1) $display("FAIL single_busy_set: got %0h expected 1", bus.fpr_busy[5]); else passed++;
    step();
    bus.fpu_wb_valid = 1; bus.fpu_wb_addr = 5; bus.fpu_wb_data = 32'h3F80_0000; step(); idle();
    checks++; if (bus.fpr_wen !== 1'b1) $display("FAIL single_wen: got %0h expected 1", bus.fpr_wen); else passed++;
    checks++; if (bus.fpr_waddr !== 5'd5) $display("FAIL single_waddr: got %0h expected 5", bus.fpr_waddr); else passed++;
    checks++; if (bus.fpr_wd !== 32'h3F80_0000) $display("FAIL single_wd: got %0h expected 3f800000", bus.fpr_wd); else passed++;
    checks++; if (bus.fpr_busy[5] !== 1'b1) $display("FAIL single_busy_held: got %0h expected 1", bus.fpr_busy[5]); else passed++;
    step();
    checks++; if (bus.fpr_busy[5] !== 1'b0) $display("FAIL single_busy_clr: got %0h expected 0", bus.fpr_busy[5]); else passed++;
    checks++; if (bus.fpr_wen !== 1'b0) $display("FAIL single_wen_idle: got %0h expected 0", bus.fpr_wen); else passed++;
  endtask

  task automatic test_three_way();
    logic [31:0] exp_d [3];
    do_reset();
    exp_d[0] = 32'h1111_0001; exp_d[1] = 32'h2222_0002; exp_d[2] = 32'h3333_0003;
    bus.fpu_wb_valid = 1; bus.fpu_wb_addr = 1; bus.fpu_wb_data = exp_d[0];
    bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 2; bus.lsu_wb_data = exp_d[1];
    bus.div_wb_valid = 1; bus.div_wb_addr = 3; bus.div_wb_data = exp_d[2];
    checks++; if (bus.div_wb_ready !== 1'b1) $display("FAIL three_ready_pre: got %0h expected 1", bus.div_wb_ready); else passed++;
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.fpr_wen !== 1'b1 || bus.fpr_waddr !== 5'(i + 1) || bus.fpr_wd !== exp_d[i])
        $display("FAIL three_write%0d: got wen=%0h addr=%0d data=%0h expected wen=1 addr=%0d data=%0h", i, bus.fpr_wen, bus.fpr_waddr, bus.fpr_wd, i + 1, exp_d[i]);
      else passed++;
      checks++; if (bus.div_wb_ready !== 1'b1) $display("FAIL three_ready%0d: got %0h expected 1", i, bus.div_wb_ready); else passed++;
      step();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.fpu_wb_valid = 1; bus.fpu_wb_addr = 5'(10 + k); bus.fpu_wb_data = 32'(k);
      bus.lsu_wb_valid = k < 5; bus.lsu_wb_addr = 5'(20 + k); bus.lsu_wb_data = 32'hA000 + 32'(k);
      step();
      checks++; if (bus.fpr_wen !== 1'b1 || bus.fpr_waddr !== 5'(10 + k))
        $display("FAIL ovf_fpu%0d: got wen=%0h addr=%0d expected wen=1 addr=%0d", k, bus.fpr_wen, bus.fpr_waddr, 10 + k);
      else passed++;
      checks++; if (bus.div_wb_ready !== (k < 2)) $display("FAIL ovf_ready%0d: got %0h expected %0h", k, bus.div_wb_ready, k < 2); else passed++;
      checks++; if (bus.wb_overflow !== (k >= 4)) $display("FAIL ovf_flag%0d: got %0h expected %0h", k, bus.wb_overflow, k >= 4); else passed++;
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      step();
      checks++; if (bus.fpr_wen !== 1'b1 || bus.fpr_waddr !== 5'(20 + j) || bus.fpr_wd !== 32'hA000 + 32'(j))
        $display("FAIL ovf_drain%0d: got wen=%0h addr=%0d data=%0h expected wen=1 addr=%0d data=%0h", j, bus.fpr_wen, bus.fpr_waddr, bus.fpr_wd, 20 + j, 32'hA000 + j);
      else passed++;
    end
    step();
    checks++; if (bus.fpr_wen !== 1'b0) $display("FAIL ovf_empty_wen: got %0h expected 0", bus.fpr_wen); else passed++;
    checks++; if (bus.wb_overflow !== 1'b1) $display("FAIL ovf_sticky: got %0h expected 1", bus.wb_overflow); else passed++;
    checks++; if (bus.div_wb_ready !== 1'b1) $display("FAIL ovf_ready_empty: got %0h expected 1", bus.div_wb_ready); else passed++;
  endtask

  task automatic test_set_wins();
    do_reset();
    bus.issue_valid = 1; bus.issue_addr = 7; step(); idle();
    bus.fpu_wb_valid = 1; bus.fpu_wb_addr = 7; bus.fpu_wb_data = 32'hDEAD_BEEF; step(); idle();
    checks++; if (bus.fpr_wen !== 1'b1 || bus.fpr_waddr !== 5'd7) $display("FAIL setwin_write: got wen=%0h addr=%0d expected wen=1 addr=7", bus.fpr_wen, bus.fpr_waddr); else passed++;
    bus.issue_valid = 1; bus.issue_addr = 7; step(); idle();
    checks++; if (bus.fpr_busy[7] !== 1'b1) $display("FAIL setwin_busy: got %0h expected 1", bus.fpr_busy[7]); else passed++;
    step();
    checks++; if (bus.fpr_busy[7] !== 1'b1) $display("FAIL setwin_busy_hold: got %0h expected 1", bus.fpr_busy[7]); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.fpu_wb_valid = 1; bus.fpu_wb_addr = 5'(1 + k); bus.fpu_wb_data = 32'(k);
      bus.lsu_wb_valid = 1; bus.lsu_wb_addr = 5'(4 + k); bus.lsu_wb_data = 32'(k + 100);
      bus.issue_valid = 1; bus.issue_addr = 5'(9 + k);
      step();
    end
    checks++; if (bus.div_wb_ready !== 1'b0) $display("FAIL rstmid_ready_pre: got %0h expected 0", bus.div_wb_ready); else passed++;
    rst = 1; step(); rst = 0; idle();
    checks++; if (bus.fpr_wen !== 1'b0) $display("FAIL rstmid_wen: got %0h expected 0", bus.fpr_wen); else passed++;
    checks++; if (bus.fpr_busy !== 32'd0) $display("FAIL rstmid_busy: got %0h expected 0", bus.fpr_busy); else passed++;
    checks++; if (bus.div_wb_ready !== 1'b1) $display("FAIL rstmid_ready: got %0h expected 1", bus.div_wb_ready); else passed++;
    step();
    checks++; if (bus.fpr_wen !== 1'b0) $display("FAIL rstmid_no_drain: got %0h expected 0", bus.fpr_wen); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      bus.fpu_wb_valid = ($urandom_range(0, 2) == 0);
      bus.fpu_wb_addr = 5'($urandom); bus.fpu_wb_data = $urandom;
      bus.lsu_wb_valid = ($urandom_range(0, 2) == 0);
      bus.lsu_wb_addr = 5'($urandom); bus.lsu_wb_data = $urandom;
      bus.issue_valid = $urandom_range(0, 1) == 1; bus.issue_addr = 5'($urandom);
      if (!bus.div_wb_valid || last_div_acc) begin
        bus.div_wb_valid = ($urandom_range(0, 3) == 0);
        bus.div_wb_addr = 5'($urandom); bus.div_wb_data = $urandom;
      end
      step();
      checks++;
      if (bus.fpr_wen !== m_wen || bus.fpr_waddr !== m_waddr || bus.fpr_wd !== m_wd || bus.fpr_busy !== m_busy ||
          bus.wb_overflow !== m_ovf || bus.div_wb_ready !== (q.size() <= DEPTH - 2)) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d: got wen=%0h addr=%0d wd=%0h busy=%0h ovf=%0h rdy=%0h expected wen=%0h addr=%0d wd=%0h busy=%0h ovf=%0h rdy=%0h",
                   c, bus.fpr_wen, bus.fpr_waddr, bus.fpr_wd, bus.fpr_busy, bus.wb_overflow, bus.div_wb_ready,
                   m_wen, m_waddr, m_wd, m_busy, m_ovf, q.size() <= DEPTH - 2);
        errs++;
      end else passed++;
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_three_way();
    test_overflow();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
